// File: rtl/pb_wire_parser.sv
// Streaming protobuf wire-format parser.
// Consumes one serialized byte per cycle and emits field records through a
// single-entry output register:
//   kind 0: scalar record (varint value, fixed32/64 value, or LEN header length)
//   kind 1: one payload byte of a LEN field (in out_value[7:0])
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        byte stream handshake; in_data byte, in_last ends message
//   out_valid/out_ready      record handshake
//   out_kind                 0 = field record, 1 = payload byte
//   out_field_number         field number of the current field
//   out_wire_type            wire type (0, 1, 2 or 5)
//   out_value                decoded value / length / payload byte
//   out_last, out_msg_last   final record of field / of message
//   err_valid, err_code      one-cycle error pulse; 0 OVERLONG, 1 ILLEGAL_WT,
//                            2 TRUNC, 3 FIELD_ZERO
module pb_wire_parser #(
  parameter int unsigned MAX_VARINT_BYTES = 10,
  parameter int unsigned MAX_KEY_BYTES    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [28:0] out_field_number,
  output logic [2:0]  out_wire_type,
  output logic [63:0] out_value,
  output logic        out_last,
  output logic        out_msg_last,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam logic [1:0] ErrOverlong  = 2'd0;
  localparam logic [1:0] ErrIllegalWt = 2'd1;
  localparam logic [1:0] ErrTrunc     = 2'd2;
  localparam logic [1:0] ErrFieldZero = 2'd3;

  typedef enum logic [2:0] {
    StKey,
    StVarint,
    StFixed,
    StLenHdr,
    StPayload,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d;
  logic [28:0] fn_q, fn_d;
  logic [2:0]  wt_q, wt_d;

  logic        out_valid_q, out_kind_q, out_last_q, out_msg_last_q;
  logic [28:0] out_fn_q;
  logic [2:0]  out_wt_q;
  logic [63:0] out_value_q;
  logic        err_valid_q;
  logic [1:0]  err_code_q;

  logic        accept;
  logic        emit, emit_kind, emit_last;
  logic [63:0] emit_value;
  logic        err;
  logic [1:0]  err_sel;

  logic [6:0]  shamt;
  logic [63:0] var_acc, fix_acc;
  logic        cont, last_varint_byte, last_key_byte;
  logic [2:0]  key_wt;
  logic        key_fn_zero, key_fn_wide, key_wt_legal;

  assign accept = in_valid && in_ready;
  assign cont   = in_data[7];
  assign shamt  = 7'(idx_q) * 7'd7;
  // Payload bits pushed past bit 63 fall off the 64-bit shift.
  assign var_acc = acc_q | ({57'd0, in_data[6:0]} << shamt);
  assign fix_acc = acc_q | ({56'd0, in_data} << {idx_q[2:0], 3'b000});

  assign last_varint_byte = (32'(idx_q) == MAX_VARINT_BYTES - 32'd1);
  assign last_key_byte    = (32'(idx_q) == MAX_KEY_BYTES - 32'd1);

  assign key_wt       = var_acc[2:0];
  assign key_fn_zero  = (var_acc[31:3] == 29'd0);
  assign key_fn_wide  = |var_acc[63:32];
  assign key_wt_legal = (key_wt == 3'd0) || (key_wt == 3'd1) ||
                        (key_wt == 3'd2) || (key_wt == 3'd5);

  // State and field-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StKey;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      fn_q    <= '0;
      wt_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      fn_q    <= fn_d;
      wt_q    <= wt_d;
    end
  end

  // Next-state and record/error decode for the accepted byte.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    fn_d       = fn_q;
    wt_d       = wt_q;
    emit       = 1'b0;
    emit_kind  = 1'b0;
    emit_last  = 1'b0;
    emit_value = '0;
    err        = 1'b0;
    err_sel    = ErrOverlong;

    if (accept) begin
      case (state_q)
        StKey: begin
          acc_d = var_acc;
          idx_d = idx_q + 4'd1;
          if (cont) begin
            if (last_key_byte) begin
              err = 1'b1; err_sel = ErrOverlong;
            end else if (in_last) begin
              err = 1'b1; err_sel = ErrTrunc;
            end
          end else if (key_fn_wide) begin
            err = 1'b1; err_sel = ErrOverlong;
          end else if (!key_wt_legal) begin
            err = 1'b1; err_sel = ErrIllegalWt;
          end else if (key_fn_zero) begin
            err = 1'b1; err_sel = ErrFieldZero;
          end else if (in_last) begin
            // A key alone never completes a record.
            err = 1'b1; err_sel = ErrTrunc;
          end else begin
            fn_d  = var_acc[31:3];
            wt_d  = key_wt;
            acc_d = '0;
            idx_d = '0;
            case (key_wt)
              3'd0:    state_d = StVarint;
              3'd1:    begin state_d = StFixed; cnt_d = 4'd8; end
              3'd2:    state_d = StLenHdr;
              3'd5:    begin state_d = StFixed; cnt_d = 4'd4; end
              default: state_d = StKey;
            endcase
          end
        end

        StVarint: begin
          acc_d = var_acc;
          idx_d = idx_q + 4'd1;
          if (cont) begin
            if (last_varint_byte) begin
              err = 1'b1; err_sel = ErrOverlong;
            end else if (in_last) begin
              err = 1'b1; err_sel = ErrTrunc;
            end
          end else begin
            emit       = 1'b1;
            emit_value = var_acc;
            emit_last  = 1'b1;
            state_d    = StKey;
            acc_d      = '0;
            idx_d      = '0;
          end
        end

        StFixed: begin
          acc_d = fix_acc;
          idx_d = idx_q + 4'd1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            emit       = 1'b1;
            emit_value = fix_acc;
            emit_last  = 1'b1;
            state_d    = StKey;
            acc_d      = '0;
            idx_d      = '0;
          end else if (in_last) begin
            err = 1'b1; err_sel = ErrTrunc;
          end
        end

        StLenHdr: begin
          acc_d = var_acc;
          idx_d = idx_q + 4'd1;
          if (cont) begin
            if (last_varint_byte) begin
              err = 1'b1; err_sel = ErrOverlong;
            end else if (in_last) begin
              err = 1'b1; err_sel = ErrTrunc;
            end
          end else if (var_acc == 64'd0) begin
            emit       = 1'b1;
            emit_value = '0;
            emit_last  = 1'b1;
            state_d    = StKey;
            acc_d      = '0;
            idx_d      = '0;
          end else if (in_last) begin
            // Header promises payload that can no longer arrive.
            err = 1'b1; err_sel = ErrTrunc;
          end else begin
            emit       = 1'b1;
            emit_value = var_acc;
            rem_d      = var_acc;
            state_d    = StPayload;
            acc_d      = '0;
            idx_d      = '0;
          end
        end

        StPayload: begin
          if (rem_q == 64'd1) begin
            emit       = 1'b1;
            emit_kind  = 1'b1;
            emit_value = {56'd0, in_data};
            emit_last  = 1'b1;
            rem_d      = '0;
            state_d    = StKey;
          end else if (in_last) begin
            err = 1'b1; err_sel = ErrTrunc;
          end else begin
            emit       = 1'b1;
            emit_kind  = 1'b1;
            emit_value = {56'd0, in_data};
            rem_d      = rem_q - 64'd1;
          end
        end

        StDrain: begin
          if (in_last) state_d = StKey;
        end

        default: state_d = StKey;
      endcase

      if (err) begin
        state_d = in_last ? StKey : StDrain;
        acc_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
        rem_d   = '0;
      end
    end
  end

  // Output comb: drain swallows bytes regardless of a held record.
  always_comb begin
    if (state_q == StDrain) in_ready = 1'b1;
    else                    in_ready = !out_valid_q || out_ready;
  end

  // Single-entry output register; a new record overwrites one being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_kind_q     <= 1'b0;
      out_fn_q       <= '0;
      out_wt_q       <= '0;
      out_value_q    <= '0;
      out_last_q     <= 1'b0;
      out_msg_last_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
    end else begin
      err_valid_q <= err;
      if (err) err_code_q <= err_sel;
      if (emit) begin
        out_valid_q    <= 1'b1;
        out_kind_q     <= emit_kind;
        out_fn_q       <= fn_q;
        out_wt_q       <= wt_q;
        out_value_q    <= emit_value;
        out_last_q     <= emit_last;
        out_msg_last_q <= in_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_kind         = out_kind_q;
  assign out_field_number = out_fn_q;
  assign out_wire_type    = out_wt_q;
  assign out_value        = out_value_q;
  assign out_last         = out_last_q;
  assign out_msg_last     = out_msg_last_q;
  assign err_valid        = err_valid_q;
  assign err_code         = err_code_q;

endmodule

// File: tb/tb_pb_wire_parser.sv
// Scoreboard bench for pb_wire_parser: directed byte streams push expected
// records/errors into queues; a negedge monitor pops and compares.
module tb_pb_wire_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_kind, out_last, out_msg_last;
  logic [28:0] out_field_number;
  logic [2:0]  out_wire_type;
  logic [63:0] out_value;
  logic        err_valid;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  pb_wire_parser #(
    .MAX_VARINT_BYTES(10),
    .MAX_KEY_BYTES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_kind(out_kind),
    .out_field_number(out_field_number),
    .out_wire_type(out_wire_type),
    .out_value(out_value),
    .out_last(out_last),
    .out_msg_last(out_msg_last),
    .err_valid(err_valid),
    .err_code(err_code)
  );

  typedef struct packed {
    logic        kind;
    logic [28:0] fn;
    logic [2:0]  wt;
    logic [63:0] value;
    logic        last;
    logic        msg_last;
  } rec_t;

  rec_t       exp_q[$];
  logic [1:0] err_q[$];
  int         checks = 0;
  int         failures = 0;

  rec_t       mon_got, mon_exp;
  logic [1:0] mon_err;

  function automatic rec_t mk(input logic k, input logic [28:0] f, input logic [2:0] w,
                              input logic [63:0] v, input logic l, input logic ml);
    rec_t r;
    r.kind = k; r.fn = f; r.wt = w; r.value = v; r.last = l; r.msg_last = ml;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: compares every transferred record and every error pulse.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = mk(out_kind, out_field_number, out_wire_type, out_value, out_last,
                   out_msg_last);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record got kind=%0d fn=%0d wt=%0d val=%0h last=%0d ml=%0d",
                 mon_got.kind, mon_got.fn, mon_got.wt, mon_got.value, mon_got.last,
                 mon_got.msg_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL record got kind=%0d fn=%0d wt=%0d val=%0h last=%0d ml=%0d exp kind=%0d fn=%0d wt=%0d val=%0h last=%0d ml=%0d",
                   mon_got.kind, mon_got.fn, mon_got.wt, mon_got.value, mon_got.last,
                   mon_got.msg_last, mon_exp.kind, mon_exp.fn, mon_exp.wt, mon_exp.value,
                   mon_exp.last, mon_exp.msg_last);
        end
      end
    end
    if (!rst && err_valid) begin
      checks++;
      if (err_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_error got code=%0d", err_code);
      end else begin
        mon_err = err_q.pop_front();
        if (err_code !== mon_err) begin
          failures++;
          $display("FAIL err_code got=%0d exp=%0d", err_code, mon_err);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 exp in_ready=1 byte=%0h", d);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [63:0] snap_value;
  logic [63:0] snap_ctl;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_out_value", out_value, 64'd0);
    chk("rst_out_fn", 64'(out_field_number), 64'd0);
    chk("rst_flags", 64'({out_kind, out_last, out_msg_last}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Varint 150
    exp_q.push_back(mk(0, 1, 0, 64'd150, 1, 1));
    send(8'h08, 0); send(8'h96, 0); send(8'h01, 1);
    idle();

    // LEN "abc"
    exp_q.push_back(mk(0, 2, 2, 64'd3, 0, 0));
    exp_q.push_back(mk(1, 2, 2, 64'h61, 0, 0));
    exp_q.push_back(mk(1, 2, 2, 64'h62, 0, 0));
    exp_q.push_back(mk(1, 2, 2, 64'h63, 1, 1));
    send(8'h12, 0); send(8'h03, 0); send(8'h61, 0); send(8'h62, 0); send(8'h63, 1);
    idle();

    // Zero-length LEN
    exp_q.push_back(mk(0, 2, 2, 64'd0, 1, 1));
    send(8'h12, 0); send(8'h00, 1);
    idle();

    // fixed32
    exp_q.push_back(mk(0, 1, 5, 64'd1, 1, 1));
    send(8'h0D, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 1);
    idle();

    // fixed64
    exp_q.push_back(mk(0, 3, 1, 64'h0807060504030201, 1, 1));
    send(8'h19, 0);
    for (int i = 1; i <= 8; i++) send(8'(i), (i == 8));
    idle();

    // Backpressure mid-payload
    exp_q.push_back(mk(0, 2, 2, 64'd6, 0, 0));
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(1, 2, 2, 64'(8'hA0 + i), (i == 5), (i == 5)));
    fork
      begin
        send(8'h12, 0); send(8'h06, 0);
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), (i == 5));
      end
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        snap_value = out_value;
        snap_ctl   = 64'({out_kind, out_last, out_msg_last, out_field_number});
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_value", out_value, snap_value);
          chk("stall_ctl", 64'({out_kind, out_last, out_msg_last, out_field_number}), snap_ctl);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle();

    // ILLEGAL_WT, drain, then a good field
    err_q.push_back(2'd1);
    send(8'h0B, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
    exp_q.push_back(mk(0, 1, 0, 64'd1, 1, 1));
    send(8'h08, 0); send(8'h01, 1);
    idle();

    // OVERLONG varint
    err_q.push_back(2'd0);
    send(8'h08, 0);
    for (int i = 0; i < 10; i++) send(8'hFF, (i == 9));
    idle();

    // FIELD_ZERO
    err_q.push_back(2'd3);
    send(8'h00, 1);
    idle();

    // TRUNC
    err_q.push_back(2'd2);
    send(8'h08, 0); send(8'h96, 1);
    idle();

    // Reset during a 10-byte payload after 4 bytes
    exp_q.push_back(mk(0, 2, 2, 64'd10, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 2, 2, 64'(8'h30 + i), 0, 0));
    send(8'h12, 0); send(8'h0A, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h30 + i), 0);
    in_valid = 1'b0;
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_value", out_value, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    exp_q.push_back(mk(0, 1, 0, 64'd5, 1, 1));
    send(8'h08, 0); send(8'h05, 1);
    idle();

    for (int n = 0; n < 50 && (exp_q.size() != 0 || err_q.size() != 0); n++) @(negedge clk);
    chk("end_rec_queue", 64'(exp_q.size()), 64'd0);
    chk("end_err_queue", 64'(err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pb_wire_parser.md
Name: pb_wire_parser

Overview:
- Streaming hardware parser for the protobuf wire format.
- Consumes a serialized message one byte per cycle.
- Splits the message into field records: key (field number and wire type) plus scalar value, or a length header followed by payload bytes.
- Sits directly downstream of the byte-stream source and feeds the typed field decoders; it is the hardware counterpart of the message-key, varint and fixed32/64 decode routines.

Parameters:
- MAX_VARINT_BYTES, 10, maximum bytes in one varint; a longer varint is an error.
- MAX_KEY_BYTES, 5, maximum bytes in a key varint.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  parser accepts a byte
- in_data  in  8  stream byte
- in_last  in  1  final byte of the message
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts the record
- out_kind  out  1  0 = field record, 1 = payload byte
- out_field_number  out  29  field number of the current field
- out_wire_type  out  3  wire type (0, 1, 2 or 5)
- out_value  out  64  varint value, fixed value, LEN length, or payload byte in [7:0]
- out_last  out  1  final record of this field
- out_msg_last  out  1  final record of the message
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  0 = OVERLONG, 1 = ILLEGAL_WT, 2 = TRUNC, 3 = FIELD_ZERO

Behaviour:
- Reset:
  - state = KEY.
  - out_valid, err_valid, out_last, out_msg_last = 0; err_code = 0.
  - All data outputs = 0.
  - Accumulators and counters cleared.
  - Reset mid-operation discards any partial field and any held record.
- Handshake:
  - A byte transfers on in_valid && in_ready.
  - A record transfers on out_valid && out_ready.
  - Single output register: in_ready = !out_valid || out_ready, except in DRAIN, where in_ready = 1.
  - Output fields stay stable while out_valid && !out_ready.
- Latency: a record is valid the cycle after its final byte is accepted. Full throughput of one byte per cycle with no stalls.
- Varint accumulation:
  - value |= (byte & 0x7F) << (7*idx).
  - Continuation is bit 7.
  - Bits shifted beyond bit 63 are discarded.
- States and transitions:
  - KEY: accumulate the key varint.
    - On the terminating byte: wire type = key[2:0], field number = key >> 3.
    - wt 3, 4, 6 or 7 -> ILLEGAL_WT.
    - field number 0 -> FIELD_ZERO.
    - wt 0 -> VARINT; wt 1 -> FIXED with count 8; wt 5 -> FIXED with count 4; wt 2 -> LEN_HDR.
    - More than MAX_KEY_BYTES, or field number wider than 29 bits -> OVERLONG.
  - VARINT: accumulate the value. On the terminating byte, emit a record (kind 0, out_last 1) and go to KEY. Continuation still set on byte MAX_VARINT_BYTES -> OVERLONG.
  - FIXED: assemble little-endian bytes, zero-extended. After the count reaches 0, emit the record and go to KEY.
  - LEN_HDR: accumulate the length varint (OVERLONG rule applies). On termination, emit a header record (kind 0, value = length, out_last = (length == 0)).
    - length 0 -> KEY.
    - otherwise -> PAYLOAD with remaining = length.
  - PAYLOAD: each byte is emitted as kind 1 with value = byte, carrying the field's field number and wire type. out_last is set on the byte where remaining = 1; then go to KEY.
  - DRAIN: after an error, consume and discard bytes until in_last is accepted, then go to KEY.
- Message end:
  - out_msg_last = in_last of the byte that completed the record.
  - in_last accepted while KEY has consumed zero bytes cannot occur, because every accepted byte belongs to a field.
  - in_last on a byte that does not complete a record -> TRUNC.
- Errors:
  - err_valid pulses for 1 cycle, the cycle after the offending byte.
  - The partial record is discarded; no record is emitted for the failing field.
  - If the offending byte has in_last set, go directly to KEY; otherwise go to DRAIN.
  - Records emitted before the error remain valid.
- Simultaneous events: a byte accept and a record accept in the same cycle are legal. The new record replaces the old one in the output register without a bubble.

Test Plan:
- Varint field: bytes 08 96 01 (last on 01) -> one record: fn=1, wt=0, value=150, out_last=1, out_msg_last=1.
- LEN field: bytes 12 03 61 62 63 -> header (fn=2, wt=2, value=3, out_last=0), then payload records 0x61, 0x62, 0x63 with out_last only on 0x63. Zero length (12 00) -> header with out_last=1 and no payload.
- Fixed fields: 0D 01 00 00 00 -> fn=1, wt=5, value=1. 19 01 02 03 04 05 06 07 08 -> fn=3, wt=1, value=0x0807060504030201.
- Backpressure: out_ready held low for 5 cycles mid-payload -> in_ready=0 and outputs stable. On release, bytes resume in order with no loss or duplication.
- Errors:
  - Key 0B -> err ILLEGAL_WT, following bytes drained up to in_last, then 08 01 parses normally.
  - 08 followed by ten 0xFF bytes -> OVERLONG.
  - Key 00 -> FIELD_ZERO.
  - 08 96 with last on 96 -> TRUNC and no record.
- Reset: assert rst during a 10-byte payload after 4 bytes -> out_valid drops immediately. Then 08 05 -> fn=1, value=5.
